hog_blk_sched: RTL
==================

HOG_BLK_SCHED -- requirements
Module: hog_blk_sched

Interface
REQ-001 Parameters SHALL be: DATA_W, 288, cell histogram width (9 bins x 32 b); CELLS_X, 80, cells per row; CELLS_Y, 60, cell rows per frame; ADDR_W, 13, cell address and block id width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse
- cell_valid  in  1  cell histogram valid
- cell_ready  out  1  cell histogram accepted when both cell_valid and cell_ready are high
- cell_bin  in  DATA_W  cell histogram
- bin  out  DATA_W  buffer write data
- i_valid  out  1  buffer write strobe
- addr_fw  out  ADDR_W  buffer write address
- blk_valid  out  1  2x2 block ready for classifier
- blk_ready  in  1  classifier accepts block
- bid  out  ADDR_W  block id
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse

Function
REQ-004 The FSM SHALL have states IDLE, RUN, ISSUE, WAIT and DONE.
REQ-005 IDLE SHALL go to RUN on start; cell_ready=0 and busy=0 in IDLE.
REQ-006 In RUN, cell_ready=1 and busy=1.
REQ-007 An accepted cell (row r, col c) SHALL drive bin=cell_bin, addr_fw=r*CELLS_X+c and i_valid=1 in the next cycle only.
REQ-008 Acceptance of a cell with r>=1 and c>=1 SHALL complete block (r-1,c-1), and the FSM SHALL go RUN->ISSUE.
REQ-009 Acceptance of any other cell SHALL leave the FSM in RUN.
REQ-010 ISSUE SHALL last exactly one cycle (the buffer write cycle) with cell_ready=0, then go to WAIT.
REQ-011 In WAIT, blk_valid=1 and bid=(r-1)*(CELLS_X-1)+(c-1).
REQ-012 blk_valid and bid SHALL remain stable until blk_ready=1, and cell_ready=0 throughout WAIT.
REQ-013 From WAIT with blk_ready=1, the FSM SHALL go to DONE if the completing cell was the last cell (CELLS_Y-1, CELLS_X-1), else to RUN.
REQ-014 Latency from accepting a completing cell to blk_valid SHALL be exactly 2 cycles.
REQ-015 DONE SHALL last one cycle with frame_done=1 and busy=1, then go to IDLE.
REQ-016 The column counter SHALL wrap CELLS_X-1->0 with a row increment.
REQ-017 The row counter SHALL wrap to 0 in DONE; addr_fw SHALL never exceed CELLS_X*CELLS_Y-1.
REQ-018 bid SHALL be a running counter incremented on each blk_valid&&blk_ready and cleared in DONE.
REQ-019 start outside IDLE SHALL be ignored, including start in DONE.
REQ-020 cell_valid outside RUN SHALL NOT be accepted.
REQ-021 blk_ready without blk_valid SHALL have no effect.

Reset
REQ-022 rst SHALL force state IDLE, counters 0, and every output 0 (cell_ready, bin, i_valid, addr_fw, blk_valid, bid, busy, frame_done) on the next clock edge.
REQ-023 rst SHALL take priority over all other inputs, including when asserted mid-frame or in WAIT; a pending block is discarded.

Structure
REQ-024 Package hog_pkg SHALL hold DATA_W, ADDR_W, CELLS_X, CELLS_Y defaults and the state enum type.
REQ-025 The row/column/linear-address counter SHALL be sub-module hog_cell_cnt (inc, clr inputs; row, col, addr, last_cell outputs).

Verification (bench uses CELLS_X=4, CELLS_Y=3)
REQ-026 Assert rst for 2 cycles -> all outputs 0, cell_ready 0.
REQ-027 Pulse start, stream 12 cells with blk_ready=1:
- addr_fw 0..11 in order;
- bid 0..5 issued after cells 5,6,7,9,10,11;
- frame_done exactly once, 1 cycle after block 5 handshake.
REQ-028 Hold blk_ready=0 for 5 cycles on bid 0 -> blk_valid=1 and bid=0 stable, cell_ready=0, i_valid=0 throughout.
REQ-029 Drive cell_valid=1 in IDLE, and pulse start mid-frame -> no cell accepted in IDLE, no counter disturbance mid-frame.
REQ-030 Assert rst while in WAIT on bid 3, then restart -> outputs 0 next cycle; new frame starts at addr_fw 0 and bid 0.
REQ-031 Pulse start in the DONE cycle, then one cycle later -> first ignored, second starts a frame at addr_fw 0.

Source files
------------

// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared defaults and FSM state type for the HOG block scheduler
package hog_pkg;

  localparam int DATA_W  = 288;
  localparam int CELLS_X = 80;
  localparam int CELLS_Y = 60;
  localparam int ADDR_W  = 13;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/hog_cell_cnt.sv
// rtl/hog_cell_cnt.sv - row/column/linear cell address counter
module hog_cell_cnt #(
  parameter int CELLS_X = hog_pkg::CELLS_X,
  parameter int CELLS_Y = hog_pkg::CELLS_Y,
  parameter int ADDR_W  = hog_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] addr,
  output logic              last_cell
);
  import hog_pkg::*;

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(CELLS_X - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(CELLS_Y - 1);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_cell = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Wrapping on the last cell keeps addr inside the frame even before clr lands
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clr) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (inc) begin
      if (last_cell) begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
      end else if (col_q == COL_MAX) begin
        col_d  = '0;
        row_d  = row_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end else begin
        col_d  = col_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;

endmodule

// File: rtl/hog_blk_sched.sv
// rtl/hog_blk_sched.sv - streams cell histograms to the buffer and issues 2x2 blocks
module hog_blk_sched #(
  parameter int DATA_W  = hog_pkg::DATA_W,
  parameter int CELLS_X = hog_pkg::CELLS_X,
  parameter int CELLS_Y = hog_pkg::CELLS_Y,
  parameter int ADDR_W  = hog_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [DATA_W-1:0] cell_bin,
  output logic [DATA_W-1:0] bin,
  output logic              i_valid,
  output logic [ADDR_W-1:0] addr_fw,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [ADDR_W-1:0] bid,
  output logic              busy,
  output logic              frame_done
);
  import hog_pkg::*;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] bin_q;
  logic              i_valid_q;
  logic [ADDR_W-1:0] addr_fw_q;
  logic [ADDR_W-1:0] bid_q;

  logic [ADDR_W-1:0] row, col, addr;
  logic              last_cell;
  logic              accept;
  logic              completes;

  assign accept    = cell_valid && cell_ready;
  assign completes = (row != '0) && (col != '0);

  hog_cell_cnt #(
    .CELLS_X (CELLS_X),
    .CELLS_Y (CELLS_Y),
    .ADDR_W  (ADDR_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (accept),
    .clr       (state_q == DONE),
    .row       (row),
    .col       (col),
    .addr      (addr),
    .last_cell (last_cell)
  );

  // last_q remembers whether the pending block closes the frame; the counter has already wrapped
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cell_ready = 1'b0;
    blk_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        cell_ready = 1'b1;
        if (cell_valid && completes) begin
          state_d = ISSUE;
          last_d  = last_cell;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = last_q ? DONE : RUN;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      bin_q     <= '0;
      i_valid_q <= 1'b0;
      addr_fw_q <= '0;
      bid_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      i_valid_q <= accept;
      if (accept) begin
        bin_q     <= cell_bin;
        addr_fw_q <= addr;
      end
      if (state_q == DONE) bid_q <= '0;
      else if (blk_valid && blk_ready) bid_q <= bid_q + 1'b1;
    end
  end

  assign bin     = bin_q;
  assign i_valid = i_valid_q;
  assign addr_fw = addr_fw_q;
  assign bid     = bid_q;

endmodule
